// File: rtl/sensor_conditioner.sv
// Sensor front end: 2-flop synchronizer, debouncer, car-request latch and tick prescaler.
// Optional macro SENSOR_LATCH_EN keeps car_waiting set until grant; otherwise it follows sensor_clean.
module sensor_conditioner #(
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic sensor_raw,
  input  logic grant,
  output logic sensor_clean,
  output logic car_waiting,
  output logic sec_tick
);
  localparam int P  = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(P);
  localparam int D  = DEBOUNCE_CYCLES;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam logic [PW-1:0] PC_LAST  = PW'(P - 1);
  localparam logic [DW-1:0] CNT_LAST = DW'(D - 1);

  logic [1:0]    sync_pipe;
  logic [DW-1:0] cnt;
  logic [PW-1:0] pc;
  logic          s2;

  assign s2 = sync_pipe[1];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_pipe    <= '0;
      cnt          <= '0;
      sensor_clean <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], sensor_raw};
      if (s2 == sensor_clean)
        cnt <= '0;
      else if (cnt == CNT_LAST) begin
        sensor_clean <= s2;
        cnt          <= '0;
      end else
        cnt <= cnt + DW'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pc       <= '0;
      sec_tick <= 1'b0;
    end else if (pc == PC_LAST) begin
      pc       <= '0;
      sec_tick <= 1'b1;
    end else begin
      pc       <= pc + PW'(1);
      sec_tick <= 1'b0;
    end
  end

`ifdef SENSOR_LATCH_EN
  logic rise_accept;
  // A rise is accepted on the edge the debouncer flips clean from 0 to 1; it beats grant.
  assign rise_accept = s2 && !sensor_clean && (cnt == CNT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset)
      car_waiting <= 1'b0;
    else if (rise_accept)
      car_waiting <= 1'b1;
    else if (grant)
      car_waiting <= 1'b0;
  end
`else
  logic grant_unused;
  assign grant_unused = grant;
  assign car_waiting  = sensor_clean;
`endif

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner (CLK_HZ=10, TICK_HZ=1, DEBOUNCE_CYCLES=4).
module tb_sensor_conditioner;
  localparam int P = 10;
  localparam int D = 4;

  logic CLOCK_50 = 1'b0;
  logic reset, sensor_raw, grant;
  logic sensor_clean, car_waiting, sec_tick;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit d1, d2;
  bit hist[$];
  bit m_clean, m_cw, m_tick;
  int n_since_rst;

  sensor_conditioner #(.CLK_HZ(10), .TICK_HZ(1), .DEBOUNCE_CYCLES(D)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .sensor_raw(sensor_raw), .grant(grant),
    .sensor_clean(sensor_clean), .car_waiting(car_waiting), .sec_tick(sec_tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // One clock edge: drive inputs at negedge, advance the model at posedge, return #1 later.
  task automatic cyc(input bit raw, input bit g, input bit rs);
    bit s2v, fire, rise;
    @(negedge CLOCK_50);
    sensor_raw = raw; grant = g; reset = rs;
    @(posedge CLOCK_50);
    if (rs) begin
      d1 = 0; d2 = 0; hist.delete();
      m_clean = 0; m_cw = 0; n_since_rst = 0;
    end else begin
      s2v = d2;
      hist.push_back(s2v);
      if (hist.size() > 2 * D) void'(hist.pop_front());
      // clean flips once the last D synchronized samples all disagree with it
      fire = (hist.size() >= D);
      for (int i = 0; i < D; i++)
        if (hist.size() > i && hist[hist.size() - 1 - i] == m_clean) fire = 0;
      rise = fire && !m_clean;
      if (fire) m_clean = !m_clean;
`ifdef SENSOR_LATCH_EN
      if (rise) m_cw = 1;
      else if (g) m_cw = 0;
`else
      m_cw = m_clean;
`endif
      d2 = d1; d1 = raw;
      n_since_rst++;
    end
    m_tick = (n_since_rst > 0) && (n_since_rst % P == 0);
    #1;
  endtask

  task automatic test_reset;
    for (int e = 1; e <= 3; e++) begin
      cyc(1, 0, 1);
      checks++;
      if ({sensor_clean, car_waiting, sec_tick} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold edge %0d: got %b%b%b want 000", e, sensor_clean, car_waiting, sec_tick);
      end
    end
    for (int e = 1; e <= 6; e++) begin
      cyc(1, 0, 0);
      checks++;
      if (sensor_clean !== (e >= 6)) begin
        errors++;
        $display("FAIL reset_release clean edge %0d: got %b want %b", e, sensor_clean, e >= 6);
      end
    end
  endtask

  task automatic test_glitch;
    cyc(0, 0, 1); cyc(0, 0, 1);
    for (int e = 1; e <= 23; e++) begin
      cyc(e <= 3, 0, 0);
      checks++;
      if ({sensor_clean, car_waiting} !== 2'b00 || {sensor_clean, car_waiting, sec_tick} !== {m_clean, m_cw, m_tick}) begin
        errors++;
        $display("FAIL glitch edge %0d: got %b%b%b want 00%b", e, sensor_clean, car_waiting, sec_tick, m_tick);
      end
    end
  endtask

`ifdef SENSOR_LATCH_EN
  task automatic test_request_grant;
    cyc(0, 0, 1);
    for (int e = 1; e <= 20; e++) begin
      cyc(e <= 8, e == 20, 0);
      checks++;
      if (car_waiting !== m_cw) begin
        errors++;
        $display("FAIL req_grant model edge %0d: got %b want %b", e, car_waiting, m_cw);
      end
      if (e == 5 || e == 6 || e == 19 || e == 20) begin
        checks++;
        if (car_waiting !== (e != 5 && e != 20)) begin
          errors++;
          $display("FAIL req_grant edge %0d: got %b want %b", e, car_waiting, e != 5 && e != 20);
        end
      end
    end
  endtask

  task automatic test_simul_set_grant;
    cyc(0, 0, 1);
    for (int e = 1; e <= 6; e++) cyc(1, 1, 0);
    checks++;
    if (car_waiting !== 1'b1 || m_cw !== 1'b1) begin
      errors++;
      $display("FAIL set_vs_grant: got %b want 1", car_waiting);
    end
    cyc(1, 1, 0);
    checks++;
    if (car_waiting !== 1'b0) begin
      errors++;
      $display("FAIL set_vs_grant_clear: got %b want 0", car_waiting);
    end
  endtask
`else
  task automatic test_no_latch;
    cyc(0, 1, 1);
    for (int e = 1; e <= 22; e++) begin
      cyc(e <= 10, e[0], 0);
      checks++;
      if (car_waiting !== sensor_clean || sensor_clean !== (e >= 6 && e < 16)) begin
        errors++;
        $display("FAIL no_latch edge %0d: got cw=%b clean=%b want %b", e, car_waiting, sensor_clean, e >= 6 && e < 16);
      end
    end
  endtask
`endif

  task automatic test_tick;
    cyc(0, 0, 1);
    for (int e = 1; e <= 35; e++) begin
      cyc($urandom_range(0, 1), 0, e == 25);
      checks++;
      if (sec_tick !== m_tick || sec_tick !== (e == 10 || e == 20 || e == 35)) begin
        errors++;
        $display("FAIL tick edge %0d: got %b want %b", e, sec_tick, m_tick);
      end
    end
  endtask

  task automatic test_random;
    bit raw = 0;
    int hold = 0;
    cyc(0, 0, 1);
    for (int e = 1; e <= 400; e++) begin
      if (hold == 0) begin
        raw  = !raw;
        hold = $urandom_range(1, 8);
      end
      hold--;
      cyc(raw, $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
      checks++;
      if ({sensor_clean, car_waiting, sec_tick} !== {m_clean, m_cw, m_tick}) begin
        errors++;
        $display("FAIL random edge %0d: got %b%b%b want %b%b%b", e, sensor_clean, car_waiting, sec_tick,
                 m_clean, m_cw, m_tick);
      end
    end
  endtask

  initial begin
    reset = 1; sensor_raw = 0; grant = 0;
    test_reset();
    test_glitch();
`ifdef SENSOR_LATCH_EN
    test_request_grant();
    test_simul_set_grant();
`else
    test_no_latch();
`endif
    test_tick();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
